// File: rtl/hash_arb_pkg.sv
// Shared types and constants for the hash core arbiter and the requesters
// that build padded SHAKE messages for it.
package hash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } arbState_t;

  localparam int MSG_W_DEFAULT = 512;
  localparam int DIG_W_DEFAULT = 256;

  // SHAKE domain-separation byte and the final padding byte used by requesters
  localparam logic [7:0] SHAKE_DOMAIN_BYTE = 8'h1f;
  localparam logic [7:0] SHAKE_FINAL_BYTE  = 8'h80;

  // Watchdog counter width; a disabled watchdog still gets a 1-bit counter
  function automatic int cntWidth(input int timeoutCyc);
    return (timeoutCyc <= 0) ? 1 : $clog2(timeoutCyc + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotating-priority encoder: picks the first set request bit scanning
// upward from the slot after the last winner, wrapping modulo N_REQ.
module rr_arbiter_n #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_rrPtr,
  output logic             o_anyReq,
  output logic [ID_W-1:0]  o_winner
);

  logic w_found;
  int   w_idx;

  assign o_anyReq = |i_req;

  // Walk the N_REQ slots after the pointer; the explicit subtract keeps the
  // wrap correct when N_REQ is not a power of two
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(i_rrPtr) + k;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        o_winner = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/hash_core_arbiter.sv
// Shares one hash core between N_REQ requesters with round-robin grants,
// returns each digest with a one-cycle done pulse and aborts hung jobs
// through a watchdog.
module hash_core_arbiter
  import hash_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MSG_W       = MSG_W_DEFAULT,
  parameter int DIG_W       = DIG_W_DEFAULT,
  parameter int TIMEOUT_CYC = 1023,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*MSG_W-1:0] req_msg,
  output logic [N_REQ-1:0]       req_done,
  output logic [N_REQ-1:0]       req_err,
  output logic [DIG_W-1:0]       digest,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic [MSG_W-1:0]       hc_msg,
  output logic                   hc_start,
  input  logic [DIG_W-1:0]       hc_digest,
  input  logic                   hc_end
);

  localparam int              CNT_W    = cntWidth(TIMEOUT_CYC);
  localparam bit              WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_REQ - 1);

  arbState_t         r_state;
  arbState_t         w_nextState;
  logic [ID_W-1:0]   r_rrPtr;
  logic [ID_W-1:0]   r_grantId;
  logic [CNT_W-1:0]  r_count;
  logic [MSG_W-1:0]  r_hcMsg;
  logic [DIG_W-1:0]  r_digest;
  logic [N_REQ-1:0]  r_reqDone;
  logic [N_REQ-1:0]  r_reqErr;
  logic              r_hcStart;

  logic              w_anyReq;
  logic [ID_W-1:0]   w_winner;
  logic              w_timeout;
  logic              w_grantFire;
  logic              w_doneFire;
  logic              w_errFire;
  logic [N_REQ-1:0]  w_ownerOneHot;

  rr_arbiter_n #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .i_req    (req_valid),
    .i_rrPtr  (r_rrPtr),
    .o_anyReq (w_anyReq),
    .o_winner (w_winner)
  );

  assign w_timeout     = WDOG_EN && (r_count == CNT_LAST);
  assign w_ownerOneHot = N_REQ'(1) << r_grantId;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; completion takes precedence over the watchdog
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq)             w_nextState = WAIT;
      WAIT:    if (hc_end || w_timeout)  w_nextState = RELEASE;
      RELEASE: if (!hc_end)              w_nextState = IDLE;
      default:                           w_nextState = IDLE;
    endcase
  end

  // Per-state strobes that drive the datapath registers
  always_comb begin
    w_grantFire = 1'b0;
    w_doneFire  = 1'b0;
    w_errFire   = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: w_grantFire = w_anyReq;
      WAIT: begin
        w_doneFire = hc_end;
        w_errFire  = !hc_end && w_timeout;
      end
      default: ;
    endcase
  end

  // Grant capture: message, owner and round-robin pointer load together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcMsg   <= '0;
      r_grantId <= '0;
      r_rrPtr   <= PTR_INIT;
    end else if (w_grantFire) begin
      r_hcMsg   <= req_msg[int'(w_winner)*MSG_W +: MSG_W];
      r_grantId <= w_winner;
      r_rrPtr   <= w_winner;
    end
  end

  // Start is high exactly while the job is in WAIT, so reset drops it at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcStart <= 1'b0;
    end else begin
      r_hcStart <= (w_nextState == WAIT);
    end
  end

  // Watchdog counter: cleared at grant, counts while waiting, saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_grantFire) begin
      r_count <= '0;
    end else if ((r_state == WAIT) && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Completion path: digest capture and one-cycle done/err pulses to the owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_digest  <= '0;
      r_reqDone <= '0;
      r_reqErr  <= '0;
    end else begin
      r_reqDone <= w_doneFire ? w_ownerOneHot : '0;
      r_reqErr  <= w_errFire  ? w_ownerOneHot : '0;
      if (w_doneFire) begin
        r_digest <= hc_digest;
      end
    end
  end

  assign req_done = r_reqDone;
  assign req_err  = r_reqErr;
  assign digest   = r_digest;
  assign grant_id = r_grantId;
  assign hc_msg   = r_hcMsg;
  assign hc_start = r_hcStart;

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Directed self-checking bench for hash_core_arbiter. One instance uses the
// default watchdog, a second uses TIMEOUT_CYC = 16 for the watchdog cases.
module tb_hash_core_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    reqValid;
  logic [2047:0] reqMsg;
  logic [255:0]  hcDigest;
  logic          hcEnd;

  logic [3:0]    reqDone, reqErr;
  logic [255:0]  digest;
  logic [1:0]    grantId;
  logic          busy;
  logic [511:0]  hcMsg;
  logic          hcStart;

  logic [3:0]    wReqDone, wReqErr;
  logic [255:0]  wDigest;
  logic [1:0]    wGrantId;
  logic          wBusy;
  logic [511:0]  wHcMsg;
  logic          wHcStart;

  int nChecks = 0;
  int nPass   = 0;

  // Free-running clock
  always #5 clk = ~clk;

  hash_core_arbiter dut (
    .clk       (clk),
    .reset     (rst_n),
    .req_valid (reqValid),
    .req_msg   (reqMsg),
    .req_done  (reqDone),
    .req_err   (reqErr),
    .digest    (digest),
    .grant_id  (grantId),
    .busy      (busy),
    .hc_msg    (hcMsg),
    .hc_start  (hcStart),
    .hc_digest (hcDigest),
    .hc_end    (hcEnd)
  );

  hash_core_arbiter #(.TIMEOUT_CYC(16)) dutWd (
    .clk       (clk),
    .reset     (rst_n),
    .req_valid (reqValid),
    .req_msg   (reqMsg),
    .req_done  (wReqDone),
    .req_err   (wReqErr),
    .digest    (wDigest),
    .grant_id  (wGrantId),
    .busy      (wBusy),
    .hc_msg    (wHcMsg),
    .hc_start  (wHcStart),
    .hc_digest (hcDigest),
    .hc_end    (hcEnd)
  );

  function automatic logic [511:0] msgOf(input int i);
    return {16{32'hC0DE_0000 | 32'(i)}};
  endfunction

  function automatic logic [255:0] digOf(input int i);
    return {8{32'h5EED_0000 | 32'(i)}};
  endfunction

  task automatic resetDut();
    rst_n    = 1'b0;
    hcEnd    = 1'b0;
    reqValid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Plays the core for one job on the default instance and reports what it saw
  task automatic serveOne(input int lat, input logic [255:0] dig, output int owner,
                          output logic [511:0] msgSeen, output logic [3:0] doneSeen);
    int waitCnt = 0;
    owner    = -1;
    msgSeen  = '0;
    doneSeen = '0;
    while (hcStart !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (hcStart !== 1'b1) return;
    owner   = int'(grantId);
    msgSeen = hcMsg;
    repeat (lat - 1) @(negedge clk);
    hcDigest = dig;
    hcEnd    = 1'b1;
    @(negedge clk);
    doneSeen        = reqDone;
    hcEnd           = 1'b0;
    reqValid[owner] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++; if (hcStart !== 1'b0) $display("[TB] FAIL reset_hc_start: got %b expected 0", hcStart); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else nPass++;
    nChecks++; if ({reqDone, reqErr} !== 8'h00) $display("[TB] FAIL reset_done_err: got %h expected 00", {reqDone, reqErr}); else nPass++;
    nChecks++; if (grantId !== 2'd0) $display("[TB] FAIL reset_grant_id: got %0d expected 0", grantId); else nPass++;
    nChecks++; if (digest !== 256'd0 || hcMsg !== 512'd0) $display("[TB] FAIL reset_data: digest %h msg %h expected 0", digest, hcMsg); else nPass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int highCnt = 0;
    resetDut();
    reqValid = 4'b0100;
    @(negedge clk);
    nChecks++; if (grantId !== 2'd2) $display("[TB] FAIL single_grant: got %0d expected 2", grantId); else nPass++;
    nChecks++; if (hcMsg !== msgOf(2)) $display("[TB] FAIL single_msg: got %h expected %h", hcMsg, msgOf(2)); else nPass++;
    for (int k = 1; k <= 24; k++) begin
      if (hcStart === 1'b1) highCnt++;
      if (k == 24) begin
        hcDigest = {32{8'hA5}};
        hcEnd    = 1'b1;
      end
      @(negedge clk);
    end
    nChecks++; if (highCnt != 24) $display("[TB] FAIL single_start_len: got %0d expected 24", highCnt); else nPass++;
    nChecks++; if (reqDone !== 4'b0100) $display("[TB] FAIL single_done: got %b expected 0100", reqDone); else nPass++;
    nChecks++; if (digest !== {32{8'hA5}}) $display("[TB] FAIL single_digest: got %h expected a5..a5", digest); else nPass++;
    nChecks++; if (hcStart !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL single_release: start %b busy %b expected 0 1", hcStart, busy); else nPass++;
    hcEnd    = 1'b0;
    reqValid = 4'b0000;
    @(negedge clk);
    nChecks++; if (reqDone !== 4'b0000) $display("[TB] FAIL single_done_width: got %b expected 0000", reqDone); else nPass++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_fall: got %b expected 0", busy); else nPass++;
  endtask

  task automatic test_simultaneous();
    int          owner;
    logic [511:0] msgSeen;
    logic [3:0]  doneSeen;
    resetDut();
    reqValid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serveOne(4 + k, digOf(k), owner, msgSeen, doneSeen);
      nChecks++; if (owner != k) $display("[TB] FAIL simul_owner%0d: got %0d expected %0d", k, owner, k); else nPass++;
      nChecks++; if (msgSeen !== msgOf(k)) $display("[TB] FAIL simul_msg%0d: got %h expected %h", k, msgSeen, msgOf(k)); else nPass++;
      nChecks++; if (doneSeen !== (4'b0001 << k)) $display("[TB] FAIL simul_done%0d: got %b expected %b", k, doneSeen, 4'b0001 << k); else nPass++;
      nChecks++; if (digest !== digOf(k)) $display("[TB] FAIL simul_digest%0d: got %h expected %h", k, digest, digOf(k)); else nPass++;
    end
  endtask

  task automatic test_rr_wrap();
    int          owner;
    logic [511:0] msgSeen;
    logic [3:0]  doneSeen;
    reqValid = 4'b1001;
    serveOne(3, digOf(8), owner, msgSeen, doneSeen);
    nChecks++; if (owner != 0) $display("[TB] FAIL wrap_first: got %0d expected 0", owner); else nPass++;
    nChecks++; if (doneSeen !== 4'b0001) $display("[TB] FAIL wrap_first_done: got %b expected 0001", doneSeen); else nPass++;
    serveOne(3, digOf(9), owner, msgSeen, doneSeen);
    nChecks++; if (owner != 3) $display("[TB] FAIL wrap_second: got %0d expected 3", owner); else nPass++;
    nChecks++; if (doneSeen !== 4'b1000) $display("[TB] FAIL wrap_second_done: got %b expected 1000", doneSeen); else nPass++;
  endtask

  task automatic test_watchdog();
    int okCnt = 0;
    resetDut();
    hcDigest = {8{32'hDEAD_BEEF}};
    reqValid = 4'b0010;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (wReqErr === 4'b0000 && wHcStart === 1'b1) okCnt++;
    end
    @(negedge clk);
    nChecks++; if (okCnt != 16) $display("[TB] FAIL wdog_wait_cycles: got %0d expected 16", okCnt); else nPass++;
    nChecks++; if (wReqErr !== 4'b0010) $display("[TB] FAIL wdog_err: got %b expected 0010", wReqErr); else nPass++;
    nChecks++; if (wHcStart !== 1'b0) $display("[TB] FAIL wdog_start: got %b expected 0", wHcStart); else nPass++;
    nChecks++; if (wDigest !== 256'd0) $display("[TB] FAIL wdog_digest: got %h expected 0", wDigest); else nPass++;
    nChecks++; if (wReqDone !== 4'b0000) $display("[TB] FAIL wdog_no_done: got %b expected 0000", wReqDone); else nPass++;
    reqValid = 4'b0000;
    @(negedge clk);
    nChecks++; if (wReqErr !== 4'b0000 || wBusy !== 1'b0) $display("[TB] FAIL wdog_recover: err %b busy %b expected 0000 0", wReqErr, wBusy); else nPass++;
    reqValid = 4'b0100;
    @(negedge clk);
    nChecks++; if (wHcStart !== 1'b1 || wGrantId !== 2'd2) $display("[TB] FAIL wdog_next_req: start %b id %0d expected 1 2", wHcStart, wGrantId); else nPass++;
    reqValid = 4'b0000;
  endtask

  task automatic test_coincident();
    resetDut();
    reqValid = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) begin
        hcDigest = {8{32'h3C3C_5A5A}};
        hcEnd    = 1'b1;
      end
    end
    @(negedge clk);
    nChecks++; if (wReqDone !== 4'b0001) $display("[TB] FAIL coinc_done: got %b expected 0001", wReqDone); else nPass++;
    nChecks++; if (wReqErr !== 4'b0000) $display("[TB] FAIL coinc_no_err: got %b expected 0000", wReqErr); else nPass++;
    nChecks++; if (wDigest !== {8{32'h3C3C_5A5A}}) $display("[TB] FAIL coinc_digest: got %h expected 3c3c5a5a..", wDigest); else nPass++;
    hcEnd    = 1'b0;
    reqValid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int          owner;
    logic [511:0] msgSeen;
    logic [3:0]  doneSeen;
    resetDut();
    reqValid = 4'b0001;
    repeat (10) @(negedge clk);
    nChecks++; if (hcStart !== 1'b1 || grantId !== 2'd0) $display("[TB] FAIL mid_job_active: start %b id %0d expected 1 0", hcStart, grantId); else nPass++;
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if (hcStart !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL mid_reset_start: start %b busy %b expected 0 0", hcStart, busy); else nPass++;
    nChecks++; if (hcMsg !== 512'd0) $display("[TB] FAIL mid_reset_msg: got %h expected 0", hcMsg); else nPass++;
    reqValid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    nChecks++; if ({reqDone, reqErr} !== 8'h00 || hcStart !== 1'b0) $display("[TB] FAIL mid_reset_hold: done/err %h start %b expected 00 0", {reqDone, reqErr}, hcStart); else nPass++;
    rst_n = 1'b1;
    serveOne(3, digOf(12), owner, msgSeen, doneSeen);
    nChecks++; if (owner != 0) $display("[TB] FAIL mid_reset_priority: got %0d expected 0", owner); else nPass++;
    nChecks++; if (doneSeen !== 4'b0001) $display("[TB] FAIL mid_reset_done: got %b expected 0001", doneSeen); else nPass++;
    reqValid = 4'b0000;
  endtask

  // Test sequence
  initial begin
    rst_n    = 1'b0;
    reqValid = 4'b0000;
    hcEnd    = 1'b0;
    hcDigest = '0;
    for (int i = 0; i < 4; i++) begin
      reqMsg[i*512 +: 512] = msgOf(i);
    end
    test_reset();
    test_single();
    test_simultaneous();
    test_rr_wrap();
    test_watchdog();
    test_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
